avalon_pwm_multi: RTL and testbench
===================================

Name: avalon_pwm_multi

Overview:
- Parametrised multi-channel PWM peripheral on an Avalon-MM slave, successor to the single-LED PWM block.
- NUM_CH independent duty channels share one programmable prescaler and one period counter.
- Every timer runs in the csi_clk domain using a tick-enable; there is no derived clock.
- Duty and period writes are double-buffered, so updates are glitch-free at period wrap.
- Optional period interrupt to the host.

Parameters:
- NUM_CH, 4, number of PWM outputs; legal range 1..12, bounded by the address map.
- CNT_W, 16, width of the period counter, PERIOD and DUTY registers; legal range 2..32.
- PRE_W, 16, width of the prescaler register/counter; legal range 1..32.

Ports:
- csi_clk  in  1  system clock, 100 MHz
- csi_reset_n  in  1  asynchronous, active-low reset
- avs_chipselect  in  1  Avalon slave select
- avs_address  in  4  word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid 1 cycle after read
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- coe_pwm_out  out  NUM_CH  PWM outputs, one per channel
- ins_irq  out  1  period-wrap interrupt, level; present only with PWM_IRQ_EN

Behaviour:
- Reset is csi_reset_n, asynchronous, active-low; clock is csi_clk.
- Register map (word address):
  - 0 CTRL: bit0 EN; bit1 POL (1 = outputs active-low); bit2 IRQ_EN.
  - 1 PRESCALE: PRE_W bits.
  - 2 PERIOD: CNT_W bits.
  - 3 STATUS: bit0 WRAP, sticky, write-1-to-clear.
  - 4..4+NUM_CH-1 DUTY[ch].
  - Unused addresses: read 0, writes ignored. Unused upper bits: read 0.
- Reset values:
  - CTRL=0x2; PRESCALE=99; PERIOD=999; DUTY=10; STATUS=0.
  - Counters=0; avs_readdata=0; ins_irq=0.
  - coe_pwm_out = all 1 (inactive under POL=1).
- Read: when chipselect&&read, avs_readdata is registered next cycle (latency 1). Otherwise it holds its last value.
- Write: when chipselect&&write, the addressed register is updated next edge. Write has priority if read and write are asserted together.
- Run state machine, two states:
  - IDLE (EN=0): prescaler and period counter held at 0; outputs driven inactive (=POL).
  - IDLE->RUN when EN=1.
  - On entering RUN, shadow PERIOD/DUTY are loaded from the live registers in the same cycle.
  - RUN->IDLE immediately when EN=0; counters clear on the next edge.
- Prescaler:
  - pre_cnt counts 0..PRESCALE.
  - tick=1 when pre_cnt==PRESCALE, then pre_cnt wraps to 0.
  - PRESCALE=0 gives a tick every clock.
- Period counter:
  - Advances on tick over 0..shadow_PERIOD; period = (shadow_PERIOD+1)*(PRESCALE+1) clocks.
  - Wrap = tick while cnt==shadow_PERIOD. At wrap: cnt->0, shadows reload from live PERIOD/DUTY, STATUS.WRAP<=1.
- Channel output: active when cnt < shadow_DUTY[ch], registered (1 clock from cnt).
  - coe_pwm_out[ch] = active XOR POL.
  - DUTY=0: never active.
  - DUTY > PERIOD: always active, 100%.
  - Unsigned compare at CNT_W.
- Live writes to PERIOD/DUTY never affect the current period.
- Live PRESCALE is used directly. A PRESCALE write lowering it below pre_cnt causes pre_cnt to wrap through 2^PRE_W. This is accepted; software changes PRESCALE only while EN=0.
- Simultaneous wrap-set and W1C of STATUS.WRAP in the same cycle: set wins.
- Reset mid-period: all state returns to reset values asynchronously.

Optional Feature:
- Macro PWM_IRQ_EN.
- Defined: ins_irq port exists; ins_irq = STATUS.WRAP & CTRL.IRQ_EN, registered.
- Undefined: ins_irq port absent; CTRL bit2 reads 0 and is not writable; STATUS.WRAP still functions for polling.

Decomposition:
- Package avalon_pwm_pkg: address constants (ADDR_CTRL=0, ADDR_PRESCALE=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_DUTY0=4), CTRL bit indices, reset-value constants, MAX_CH=12.
- Sub-module pwm_channel: one instance per channel via generate. Holds live/shadow DUTY, the compare and the output register; inputs cnt, wrap, load, POL.

Test Plan:
- Reset, read all registers -> CTRL=0x2, PRESCALE=99, PERIOD=999, DUTY0..3=10, STATUS=0; coe_pwm_out=4'hF.
- PRESCALE=0, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, CTRL=1 -> 10-clock period. ch0 high 3 clocks (POL=0); ch1 constant 0; ch2 constant 1.
- Mid-period write DUTY0=7 -> current period still 3 high; next period 7 high, starting exactly at wrap.
- PRESCALE=4, PERIOD=3 -> period 20 clocks; STATUS.WRAP sets at each wrap; writing 1 clears it. W1C in the same cycle as wrap -> WRAP stays 1.
- CTRL toggled 1->0 mid-period -> outputs go inactive next cycle, counters 0. Re-enable -> period restarts from cnt=0 with fresh shadows. Assert csi_reset_n mid-period -> all values return to reset state asynchronously.
- With PWM_IRQ_EN, CTRL=0x5 -> ins_irq rises 1 clock after WRAP and falls after W1C. Without the macro, CTRL bit2 reads back 0.

Source files
------------

// File: rtl/avalon_pwm_pkg.sv
// Shared constants for the multi-channel Avalon PWM peripheral: register
// word addresses, CTRL bit positions, reset values and the run-state type.
package avalon_pwm_pkg;

    // Word addresses on the Avalon slave
    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_PRESCALE = 4'd1;
    localparam logic [3:0] ADDR_PERIOD   = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_DUTY0    = 4'd4;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_POL    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STATUS_WRAP = 0;

    // Reset values, truncated to the configured widths where they are used
    localparam int RST_PRESCALE = 99;
    localparam int RST_PERIOD   = 999;
    localparam int RST_DUTY     = 10;

    // The duty registers fill word addresses 4..15
    localparam int MAX_CH = 12;

    // Run state: IDLE holds the timers cleared, RUN lets them advance
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: live DUTY register, its shadow copy used for the current
// period, and the registered compare against the shared period counter.
module pwm_channel
    import avalon_pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             csi_clk,
    input  logic             csi_reset_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [CNT_W-1:0] cnt,
    input  logic             load,
    input  logic             run,
    input  logic             pol,
    output logic [CNT_W-1:0] duty,
    output logic             pwm_out
);

    localparam logic [CNT_W-1:0] RST_DUTY_W = CNT_W'(RST_DUTY);

    logic [CNT_W-1:0] shadow_duty;

    // Live DUTY register, written from the bus at any time
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            duty <= RST_DUTY_W;
        end else if (wr_en) begin
            duty <= wr_data;
        end
    end

    // Shadow DUTY only follows the live value at run start and period wrap
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            shadow_duty <= RST_DUTY_W;
        end else if (load) begin
            shadow_duty <= duty;
        end
    end

    // Registered output; idle forces the inactive level, which equals POL
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            pwm_out <= 1'b1;
        end else begin
            pwm_out <= (run && (cnt < shadow_duty)) ^ pol;
        end
    end

endmodule

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM on an Avalon-MM slave. One prescaler and one period
// counter are shared by NUM_CH duty channels; PERIOD and DUTY are
// double-buffered and take effect at run start or at period wrap.
// Optional macro PWM_IRQ_EN adds CTRL.IRQ_EN and the ins_irq output.
//
// Bus handshake: a transfer happens on any edge where avs_chipselect is high
// together with avs_write or avs_read; there is no wait-request. Writes update
// the addressed register on that edge, reads return avs_readdata one cycle
// later, and a write in the same cycle as a read suppresses the read.
module avalon_pwm_multi
    import avalon_pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 16
) (
    input  logic              csi_clk,
    input  logic              csi_reset_n,
    input  logic              avs_chipselect,
    input  logic [3:0]        avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [NUM_CH-1:0] coe_pwm_out
`ifdef PWM_IRQ_EN
    ,
    output logic              ins_irq
`endif
);

    localparam logic [PRE_W-1:0] RST_PRE_W = PRE_W'(RST_PRESCALE);
    localparam logic [CNT_W-1:0] RST_PER_W = CNT_W'(RST_PERIOD);

    run_state_e       state;
    logic             ctrl_en;
    logic             ctrl_pol;
`ifdef PWM_IRQ_EN
    logic             ctrl_irq_en;
`endif
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] shadow_period;
    logic [CNT_W-1:0] cnt;
    logic             status_wrap;
    logic [CNT_W-1:0] duty_live [NUM_CH];

    logic             wr_sel;
    logic             rd_sel;
    logic             run_active;
    logic             enter_run;
    logic             tick;
    logic             wrap;
    logic             load;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_sel     = avs_chipselect & avs_write;
    assign rd_sel     = avs_chipselect & avs_read & ~avs_write;
    // Dropping EN stops the timers and outputs in the same cycle
    assign run_active = (state == ST_RUN) & ctrl_en;
    assign enter_run  = (state == ST_IDLE) & ctrl_en;
    assign tick       = run_active & (pre_cnt == prescale);
    assign wrap       = tick & (cnt == shadow_period);
    assign load       = enter_run | wrap;

    // Upper write-data bits beyond the register widths are don't-care
    assign unused_wdata = ^avs_writedata;

    // Control and timing registers written from the bus
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_pol    <= 1'b1;
`ifdef PWM_IRQ_EN
            ctrl_irq_en <= 1'b0;
`endif
            prescale    <= RST_PRE_W;
            period      <= RST_PER_W;
        end else if (wr_sel) begin
            case (avs_address)
                ADDR_CTRL: begin
                    ctrl_en     <= avs_writedata[CTRL_EN];
                    ctrl_pol    <= avs_writedata[CTRL_POL];
`ifdef PWM_IRQ_EN
                    ctrl_irq_en <= avs_writedata[CTRL_IRQ_EN];
`endif
                end
                ADDR_PRESCALE: prescale <= avs_writedata[PRE_W-1:0];
                ADDR_PERIOD:   period   <= avs_writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Sticky WRAP flag; a wrap in the same cycle as a clear keeps it set
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            status_wrap <= 1'b0;
        end else if (wrap) begin
            status_wrap <= 1'b1;
        end else if (wr_sel && (avs_address == ADDR_STATUS) && avs_writedata[STATUS_WRAP]) begin
            status_wrap <= 1'b0;
        end
    end

    // Run FSM with the prescaler, period counter and shadow PERIOD
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state         <= ST_IDLE;
            pre_cnt       <= '0;
            cnt           <= '0;
            shadow_period <= RST_PER_W;
        end else begin
            case (state)
                ST_IDLE: begin
                    pre_cnt <= '0;
                    cnt     <= '0;
                    if (ctrl_en) begin
                        state         <= ST_RUN;
                        shadow_period <= period;
                    end
                end
                ST_RUN: begin
                    if (!ctrl_en) begin
                        state   <= ST_IDLE;
                        pre_cnt <= '0;
                        cnt     <= '0;
                    end else if (tick) begin
                        pre_cnt <= '0;
                        if (wrap) begin
                            cnt           <= '0;
                            shadow_period <= period;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read multiplexer; unused addresses and upper bits read as zero
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN]     = ctrl_en;
                rd_mux[CTRL_POL]    = ctrl_pol;
`ifdef PWM_IRQ_EN
                rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
`endif
            end
            ADDR_PRESCALE: rd_mux[PRE_W-1:0]  = prescale;
            ADDR_PERIOD:   rd_mux[CNT_W-1:0]  = period;
            ADDR_STATUS:   rd_mux[STATUS_WRAP] = status_wrap;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == 4'(ADDR_DUTY0 + i)) begin
                rd_mux[CNT_W-1:0] = duty_live[i];
            end
        end
    end

    // Read data register; holds its value between reads
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            avs_readdata <= '0;
        end else if (rd_sel) begin
            avs_readdata <= rd_mux;
        end
    end

`ifdef PWM_IRQ_EN
    // Level interrupt, one cycle behind the WRAP flag
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            ins_irq <= 1'b0;
        end else begin
            ins_irq <= status_wrap & ctrl_irq_en;
        end
    end
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .csi_clk     (csi_clk),
            .csi_reset_n (csi_reset_n),
            .wr_en       (wr_sel && (avs_address == 4'(ADDR_DUTY0 + g))),
            .wr_data     (avs_writedata[CNT_W-1:0]),
            .cnt         (cnt),
            .load        (load),
            .run         (run_active),
            .pol         (ctrl_pol),
            .duty        (duty_live[g]),
            .pwm_out     (coe_pwm_out[g])
        );
    end

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Bench for avalon_pwm_multi (default parameters, NUM_CH=4). A period-level
// model predicts outputs each cycle; directed steps add literal checks.
module tb_avalon_pwm_multi;

    localparam int NUM_CH = 4;

    logic              csi_clk = 1'b0;
    logic              csi_reset_n = 1'b0;
    logic              avs_chipselect = 1'b0;
    logic [3:0]        avs_address = '0;
    logic              avs_read = 1'b0;
    logic [31:0]       avs_readdata;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [NUM_CH-1:0] coe_pwm_out;
`ifdef PWM_IRQ_EN
    logic              ins_irq;
`endif

    avalon_pwm_multi dut (
        .csi_clk        (csi_clk),
        .csi_reset_n    (csi_reset_n),
        .avs_chipselect (avs_chipselect),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .coe_pwm_out    (coe_pwm_out)
`ifdef PWM_IRQ_EN
        ,
        .ins_irq        (ins_irq)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 csi_clk = ~csi_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks position inside the current period in clocks; the expected
    // output is (clocks_into_period / (prescale+1)) < duty, one clock late.
    bit                m_en, m_pol, m_ie, m_run, m_wrap, m_irq, wrap_now;
    int unsigned       m_pre, m_per, m_s, m_p, m_phase;
    int unsigned       m_duty [NUM_CH];
    int unsigned       m_d    [NUM_CH];
    logic [NUM_CH-1:0] m_out;
    logic [31:0]       m_rd;

    function automatic logic [31:0] model_reg(input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            4'd0: v = {29'b0, m_ie, m_pol, m_en};
            4'd1: v = m_pre;
            4'd2: v = m_per;
            4'd3: v = {31'b0, m_wrap};
            4'd4, 4'd5, 4'd6, 4'd7: v = m_duty[a - 4'd4];
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            m_en = 0; m_pol = 1; m_ie = 0; m_run = 0; m_wrap = 0; m_irq = 0;
            m_pre = 99; m_per = 999; m_s = 99; m_p = 999; m_phase = 0;
            for (int c = 0; c < NUM_CH; c++) begin m_duty[c] = 10; m_d[c] = 10; end
            m_out = '1;
            m_rd = '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_run && m_en)
                    m_out[c] = ((m_phase / (m_s + 1)) < m_d[c]) ^ m_pol;
                else
                    m_out[c] = m_pol;
            end
            m_irq = m_wrap & m_ie;
            if (avs_chipselect && avs_read && !avs_write) m_rd = model_reg(avs_address);
            wrap_now = 0;
            if (m_run && m_en) begin
                m_phase++;
                if (m_phase == (m_p + 1) * (m_s + 1)) begin
                    wrap_now = 1;
                    m_phase = 0;
                    m_p = m_per;
                    m_d = m_duty;
                end
            end else if (!m_run && m_en) begin
                m_run = 1; m_phase = 0; m_p = m_per; m_d = m_duty; m_s = m_pre;
            end else if (m_run && !m_en) begin
                m_run = 0;
            end
            if (avs_chipselect && avs_write) begin
                case (avs_address)
                    4'd0: begin
                        m_en  = avs_writedata[0];
                        m_pol = avs_writedata[1];
`ifdef PWM_IRQ_EN
                        m_ie  = avs_writedata[2];
`endif
                    end
                    4'd1: m_pre = 32'(avs_writedata[15:0]);
                    4'd2: m_per = 32'(avs_writedata[15:0]);
                    4'd3: if (avs_writedata[0]) m_wrap = 0;
                    4'd4, 4'd5, 4'd6, 4'd7: m_duty[avs_address - 4'd4] = 32'(avs_writedata[15:0]);
                    default: ;
                endcase
            end
            if (wrap_now) m_wrap = 1;
        end
    end

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge csi_clk) begin
        if (chk_on && csi_reset_n) begin
            check("pwm_out", 32'(coe_pwm_out), 32'(m_out));
            check("readdata", avs_readdata, m_rd);
`ifdef PWM_IRQ_EN
            check("ins_irq", 32'(ins_irq), 32'(m_irq));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        avs_chipselect = 1; avs_write = 1; avs_address = a; avs_writedata = d;
        @(negedge csi_clk);
        avs_chipselect = 0; avs_write = 0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
        avs_chipselect = 1; avs_read = 1; avs_address = a;
        @(negedge csi_clk);
        avs_chipselect = 0; avs_read = 0;
        v = avs_readdata;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] v;
        bus_rd(a, v);
        check(nm, v, exp);
    endtask

    task automatic wait_rise(input int ch, input string nm);
        logic prev;
        bit   ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            prev = coe_pwm_out[ch];
            @(negedge csi_clk);
            if (!prev && coe_pwm_out[ch]) begin ok = 1; break; end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    task automatic count_high(input int ch, output int n);
        n = 0;
        while (coe_pwm_out[ch] && n < 500) begin
            n++;
            @(negedge csi_clk);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int          n;
        int          h [NUM_CH];
        logic [31:0] v;
        bit          got;

        repeat (3) @(negedge csi_clk);
        csi_reset_n = 1;
        chk_on = 1;

        // Reset values
        check("rst_pwm", 32'(coe_pwm_out), 32'hF);
        check("rst_readdata", avs_readdata, 32'h0);
        rd_chk(4'd0, 32'h2, "rst_ctrl");
        rd_chk(4'd1, 32'd99, "rst_prescale");
        rd_chk(4'd2, 32'd999, "rst_period");
        rd_chk(4'd3, 32'h0, "rst_status");
        for (int c = 0; c < NUM_CH; c++) rd_chk(4'(4 + c), 32'd10, "rst_duty");
        bus_wr(4'd12, 32'hFFFF_FFFF);
        rd_chk(4'd12, 32'h0, "unused_addr");

        // 10-clock period with several duty patterns, POL=0
        bus_wr(4'd1, 32'd0);
        bus_wr(4'd2, 32'd9);
        bus_wr(4'd4, 32'd3);
        bus_wr(4'd5, 32'd0);
        bus_wr(4'd6, 32'd10);
        bus_wr(4'd7, 32'd5);
        bus_wr(4'd0, 32'h1);
        repeat (3) @(negedge csi_clk);
        for (int c = 0; c < NUM_CH; c++) h[c] = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge csi_clk);
            for (int c = 0; c < NUM_CH; c++) h[c] += int'(coe_pwm_out[c]);
        end
        check("duty3_high", 32'(h[0]), 32'd3);
        check("duty0_high", 32'(h[1]), 32'd0);
        check("duty_over_period", 32'(h[2]), 32'd10);
        check("duty5_high", 32'(h[3]), 32'd5);

        // Mid-period DUTY0 write only affects the next period
        wait_rise(0, "rise_before_update");
        bus_wr(4'd4, 32'd7);
        count_high(0, n);
        check("cur_period_run", 32'(n + 1), 32'd3);
        wait_rise(0, "rise_after_update");
        count_high(0, n);
        check("next_period_run", 32'(n), 32'd7);

        // PRESCALE=4, PERIOD=3 -> 20-clock period, WRAP flag behaviour
        bus_wr(4'd0, 32'h0);
        bus_wr(4'd1, 32'd4);
        bus_wr(4'd2, 32'd3);
        bus_wr(4'd4, 32'd2);
        bus_wr(4'd3, 32'h1);
        rd_chk(4'd3, 32'h0, "status_cleared_idle");
        bus_wr(4'd0, 32'h1);
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            bus_rd(4'd3, v);
            if (v[0]) got = 1;
        end
        check("wrap_set", 32'(got), 32'd1);
        wait_rise(0, "rise_pre4");
        count_high(0, n);
        check("pre4_run", 32'(n), 32'd10);
        bus_wr(4'd3, 32'h1);
        rd_chk(4'd3, 32'h0, "w1c_clear");
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (m_run && m_phase == (m_p + 1) * (m_s + 1) - 1) got = 1;
            else @(negedge csi_clk);
        end
        check("found_wrap_slot", 32'(got), 32'd1);
        bus_wr(4'd3, 32'h1);
        rd_chk(4'd3, 32'h1, "w1c_vs_wrap");

        // Interrupt enable bit
        bus_wr(4'd0, 32'h5);
`ifdef PWM_IRQ_EN
        rd_chk(4'd0, 32'h5, "ctrl_irq_en");
        check("irq_high", 32'(ins_irq), 32'd1);
        bus_wr(4'd3, 32'h1);
        @(negedge csi_clk);
        check("irq_low", 32'(ins_irq), 32'd0);
`else
        rd_chk(4'd0, 32'h1, "ctrl_bit2_masked");
`endif

        // Disable mid-period, then restart from a fresh period
        repeat (3) @(negedge csi_clk);
        bus_wr(4'd0, 32'h0);
        @(negedge csi_clk);
        check("disable_inactive", 32'(coe_pwm_out), 32'h0);
        bus_wr(4'd0, 32'h1);
        wait_rise(0, "rise_reenable");
        count_high(0, n);
        check("reenable_run", 32'(n), 32'd10);

        // Asynchronous reset mid-period
        repeat (7) @(negedge csi_clk);
        chk_on = 0;
        #2 csi_reset_n = 0;
        #1;
        check("async_rst_pwm", 32'(coe_pwm_out), 32'hF);
        check("async_rst_readdata", avs_readdata, 32'h0);
`ifdef PWM_IRQ_EN
        check("async_rst_irq", 32'(ins_irq), 32'd0);
`endif
        repeat (2) @(negedge csi_clk);
        csi_reset_n = 1;
        chk_on = 1;
        rd_chk(4'd0, 32'h2, "post_rst_ctrl");
        rd_chk(4'd2, 32'd999, "post_rst_period");
        rd_chk(4'd4, 32'd10, "post_rst_duty0");
        check("post_rst_pwm", 32'(coe_pwm_out), 32'hF);

        repeat (2) @(negedge csi_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
